sc_global_vel_rotator: RTL and testbench
========================================

// Module: sc_global_vel_rotator
// PURPOSE
//  Responder end of the global-velocity start_multiply/complete handshake. On a start pulse it
//  latches the robot-frame velocity (vx, vy) and the CORDIC cos/sin of the heading. It then rotates
//  the velocity into the global frame: gx = vx*cos - vy*sin, gy = vx*sin + vy*cos.
//  Arithmetic: one shared sequential signed multiplier, Q-format rounding, saturation.
//  Completion is reported to the global-velocity sequencer by a one-cycle complete pulse.
// PARAMETERS
//  DATA_W  16  width of vx, vy, cos, sin (signed two's complement)
//  FRAC_W  14  fractional bits of cos/sin (Q2.14; 16384 = +1.0)
//  OUT_W   16  width of gx, gy (signed)
// PORTS
//  SC_GLOBAL_VEL_ROTATOR_CLOCK_50      in   1       system clock; all logic on its rising edge
//  SC_GLOBAL_VEL_ROTATOR_RESET_InHigh  in   1       asynchronous, active-high reset
//  SC_GLOBAL_VEL_ROTATOR_start_InHigh  in   1       one-cycle request (start_multiply from sequencer)
//  SC_GLOBAL_VEL_ROTATOR_vx_In         in   DATA_W  robot-frame x velocity
//  SC_GLOBAL_VEL_ROTATOR_vy_In         in   DATA_W  robot-frame y velocity
//  SC_GLOBAL_VEL_ROTATOR_cos_In        in   DATA_W  cos(heading), Q2.FRAC_W
//  SC_GLOBAL_VEL_ROTATOR_sin_In        in   DATA_W  sin(heading), Q2.FRAC_W
//  SC_GLOBAL_VEL_ROTATOR_gx_Out        out  OUT_W   global-frame x velocity (registered)
//  SC_GLOBAL_VEL_ROTATOR_gy_Out        out  OUT_W   global-frame y velocity (registered)
//  SC_GLOBAL_VEL_ROTATOR_complete_Out  out  1       one-cycle pulse; gx/gy valid from this cycle
//  SC_GLOBAL_VEL_ROTATOR_busy_Out      out  1       high in every state except IDLE
//  SC_GLOBAL_VEL_ROTATOR_sat_Out       out  1       gx or gy saturated in the last result
// BEHAVIOUR
//  - Reset (async): state=IDLE; gx, gy, complete, busy and sat all 0; accumulator and core cleared.
//  - Reset mid-operation aborts the computation. No complete is issued.
//  - FSM states:
//    IDLE -> ISSUE(k) -> WAIT(k) -> ACC(k); k = 0..3. After ACC(3): ROUND -> DONE -> IDLE.
//  - IDLE: start=1 latches vx/vy/cos/sin, clears the accumulator, moves to ISSUE(0).
//  - Start in any other state, including DONE, is ignored. Operands are not re-latched.
//  - Product order:
//    k0 = vx*cos (acc_x += p), k1 = vy*sin (acc_x -= p), k2 = vx*sin (acc_y += p), k3 = vy*cos (acc_y += p).
//  - ISSUE: go=1 to the core for 1 cycle.
//  - WAIT: DATA_W cycles; leave on core done.
//  - ACC: add or subtract the 2*DATA_W product into a 2*DATA_W+2 signed accumulator.
//  - ROUND: for each axis, r = (acc + 2^(FRAC_W-1)) >>> FRAC_W (round half up).
//    Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; register gx/gy/sat.
//  - DONE: complete=1 for exactly one cycle, then IDLE.
//  - Latency: start high in cycle 0 -> complete high in cycle 4*(DATA_W+2)+2 (74 at defaults).
//    Latency is fixed and independent of the data.
//  - gx/gy/sat hold their values until the next ROUND. They are not cleared by a new start.
//  - The core is exact for all operand pairs, including -2^(DATA_W-1) * -2^(DATA_W-1).
// STRUCTURE
//  - Shared package: FSM state encoding localparams (IDLE..DONE) and the Q-format constants
//    (FRAC_W, ONE = 2^FRAC_W, round constant).
//  - One sub-module: sc_seq_mult_core.
//    DATA_W-cycle radix-2 signed shift-add multiplier; go/done/product interface.
//    done is high in the DATA_W-th cycle after go; product is held until the next go.
//  - Top level: FSM, operand mux into the core, accumulators, round/saturate, output registers.
// TESTING
//  1. vx=1000 vy=0 cos=16384 sin=0 -> gx=1000, gy=0, sat=0; complete 74 cycles after start.
//     busy high for cycles 1..74.
//  2. vx=1000 vy=500 cos=0 sin=16384 -> gx=-500, gy=1000, sat=0.
//  3. vx=vy=10000 cos=sin=11585 -> gx=0, gy=14142 (rounding check), sat=0.
//  4. vx=vy=32767 cos=sin=16384 -> gx=0, gy=32767, sat=1.
//     vx=-32768 vy=0 cos=-16384 sin=0 -> gx=32767, gy=0, sat=1.
//  5. Second start at cycles 10 and 74 of a run -> both ignored; single complete.
//     Results match the first operands even though the inputs changed after cycle 0.
//  6. Reset asserted at cycle 30 -> all outputs 0 immediately, no complete.
//     A start after reset release gives the correct result at +74.

Source files
------------

// File: rtl/sc_global_vel_rotator_pkg.sv
// Shared FSM encoding and Q2.14 fixed-point constants for the global-velocity rotator.
package sc_global_vel_rotator_pkg;

  localparam int Q_FRAC_W = 14;
  localparam int Q_ONE    = 1 << Q_FRAC_W;
  localparam int Q_RND    = 1 << (Q_FRAC_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACC,
    ST_ROUND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sc_seq_mult_core.sv
// Radix-2 signed shift-add multiplier: DATA_W cycles per product, done in the last cycle.
module sc_seq_mult_core #(
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  input  logic signed [DATA_W-1:0]     a,
  input  logic signed [DATA_W-1:0]     b,
  output logic                         done,
  output logic signed [2*DATA_W-1:0]   product
);

  localparam int PW = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic signed [PW-1:0] mcand;
  logic [DATA_W-1:0]    mplier;
  logic [CW-1:0]        cnt;
  logic                 run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      product <= '0;
    end else if (go) begin
      mcand   <= {{DATA_W{a[DATA_W-1]}}, a};
      mplier  <= b;
      cnt     <= '0;
      run     <= 1'b1;
      product <= '0;
    end else if (run) begin
      // The multiplier's sign bit carries weight -2^(DATA_W-1), so the last step subtracts.
      if (mplier[0]) begin
        product <= (cnt == LAST) ? product - mcand : product + mcand;
      end
      mcand  <= mcand <<< 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) run <= 1'b0;
    end
  end

  assign done = run && (cnt == LAST);

endmodule

// File: rtl/sc_global_vel_rotator.sv
// Rotates robot-frame velocity into the global frame using four products on one shared multiplier.
// Fixed latency: start -> complete in 4*(DATA_W+2)+2 cycles; starts while busy are ignored.
module sc_global_vel_rotator
  import sc_global_vel_rotator_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = Q_FRAC_W,
  parameter int OUT_W  = 16
) (
  input  logic                     SC_GLOBAL_VEL_ROTATOR_CLOCK_50,
  input  logic                     SC_GLOBAL_VEL_ROTATOR_RESET_InHigh,
  input  logic                     SC_GLOBAL_VEL_ROTATOR_start_InHigh,
  input  logic signed [DATA_W-1:0] SC_GLOBAL_VEL_ROTATOR_vx_In,
  input  logic signed [DATA_W-1:0] SC_GLOBAL_VEL_ROTATOR_vy_In,
  input  logic signed [DATA_W-1:0] SC_GLOBAL_VEL_ROTATOR_cos_In,
  input  logic signed [DATA_W-1:0] SC_GLOBAL_VEL_ROTATOR_sin_In,
  output logic signed [OUT_W-1:0]  SC_GLOBAL_VEL_ROTATOR_gx_Out,
  output logic signed [OUT_W-1:0]  SC_GLOBAL_VEL_ROTATOR_gy_Out,
  output logic                     SC_GLOBAL_VEL_ROTATOR_complete_Out,
  output logic                     SC_GLOBAL_VEL_ROTATOR_busy_Out,
  output logic                     SC_GLOBAL_VEL_ROTATOR_sat_Out
);

  localparam int PW = 2 * DATA_W;
  localparam int AW = 2 * DATA_W + 2;
  localparam logic signed [AW-1:0] RND  = {{(AW-1){1'b0}}, 1'b1} << (FRAC_W - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic clk, rst;
  assign clk = SC_GLOBAL_VEL_ROTATOR_CLOCK_50;
  assign rst = SC_GLOBAL_VEL_ROTATOR_RESET_InHigh;

  state_t state, state_nx;
  logic [1:0] k;
  logic signed [DATA_W-1:0] vx, vy, cs, sn;
  logic signed [DATA_W-1:0] mul_a, mul_b;
  logic signed [AW-1:0] acc_x, acc_y, rx, ry, prod_ext;
  logic signed [PW-1:0] product;
  logic signed [OUT_W-1:0] gx, gy;
  logic go, mul_done, sat;
  logic [OUT_W:0] cx, cy;

  sc_seq_mult_core #(.DATA_W(DATA_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .a       (mul_a),
    .b       (mul_b),
    .done    (mul_done),
    .product (product)
  );

  // Product order: vx*cos, vy*sin, vx*sin, vy*cos.
  always_comb begin
    mul_a = vx;
    mul_b = cs;
    case (k)
      2'd0: begin mul_a = vx; mul_b = cs; end
      2'd1: begin mul_a = vy; mul_b = sn; end
      2'd2: begin mul_a = vx; mul_b = sn; end
      default: begin mul_a = vy; mul_b = cs; end
    endcase
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    case (state)
      ST_IDLE:  if (SC_GLOBAL_VEL_ROTATOR_start_InHigh) state_nx = ST_ISSUE;
      ST_ISSUE: begin go = 1'b1; state_nx = ST_WAIT; end
      ST_WAIT:  if (mul_done) state_nx = ST_ACC;
      ST_ACC:   state_nx = (k == 2'd3) ? ST_ROUND : ST_ISSUE;
      ST_ROUND: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  function automatic logic [OUT_W:0] clip(input logic signed [AW-1:0] v);
    if (v > MAXV)      clip = {1'b1, MAXV[OUT_W-1:0]};
    else if (v < MINV) clip = {1'b1, MINV[OUT_W-1:0]};
    else               clip = {1'b0, v[OUT_W-1:0]};
  endfunction

  assign prod_ext = {{(AW-PW){product[PW-1]}}, product};
  assign rx = (acc_x + RND) >>> FRAC_W;
  assign ry = (acc_y + RND) >>> FRAC_W;
  assign cx = clip(rx);
  assign cy = clip(ry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
      vx    <= '0;
      vy    <= '0;
      cs    <= '0;
      sn    <= '0;
      acc_x <= '0;
      acc_y <= '0;
      gx    <= '0;
      gy    <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && SC_GLOBAL_VEL_ROTATOR_start_InHigh) begin
        vx    <= SC_GLOBAL_VEL_ROTATOR_vx_In;
        vy    <= SC_GLOBAL_VEL_ROTATOR_vy_In;
        cs    <= SC_GLOBAL_VEL_ROTATOR_cos_In;
        sn    <= SC_GLOBAL_VEL_ROTATOR_sin_In;
        acc_x <= '0;
        acc_y <= '0;
        k     <= '0;
      end
      if (state == ST_ACC) begin
        case (k)
          2'd0:    acc_x <= acc_x + prod_ext;
          2'd1:    acc_x <= acc_x - prod_ext;
          default: acc_y <= acc_y + prod_ext;
        endcase
        k <= k + 1'b1;
      end
      if (state == ST_ROUND) begin
        gx  <= cx[OUT_W-1:0];
        gy  <= cy[OUT_W-1:0];
        sat <= cx[OUT_W] | cy[OUT_W];
      end
    end
  end

  assign SC_GLOBAL_VEL_ROTATOR_gx_Out       = gx;
  assign SC_GLOBAL_VEL_ROTATOR_gy_Out       = gy;
  assign SC_GLOBAL_VEL_ROTATOR_sat_Out      = sat;
  assign SC_GLOBAL_VEL_ROTATOR_complete_Out = (state == ST_DONE);
  assign SC_GLOBAL_VEL_ROTATOR_busy_Out     = (state != ST_IDLE);

endmodule

// File: tb/tb_sc_global_vel_rotator.sv
// Directed bench for sc_global_vel_rotator: hand-computed rotations, latency, ignored starts, reset abort.
module tb_sc_global_vel_rotator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [15:0] vx = '0, vy = '0, cs = '0, sn = '0;
  logic signed [15:0] gx, gy;
  logic complete, busy, sat;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sc_global_vel_rotator dut (
    .SC_GLOBAL_VEL_ROTATOR_CLOCK_50     (clk),
    .SC_GLOBAL_VEL_ROTATOR_RESET_InHigh (rst),
    .SC_GLOBAL_VEL_ROTATOR_start_InHigh (start),
    .SC_GLOBAL_VEL_ROTATOR_vx_In        (vx),
    .SC_GLOBAL_VEL_ROTATOR_vy_In        (vy),
    .SC_GLOBAL_VEL_ROTATOR_cos_In       (cs),
    .SC_GLOBAL_VEL_ROTATOR_sin_In       (sn),
    .SC_GLOBAL_VEL_ROTATOR_gx_Out       (gx),
    .SC_GLOBAL_VEL_ROTATOR_gy_Out       (gy),
    .SC_GLOBAL_VEL_ROTATOR_complete_Out (complete),
    .SC_GLOBAL_VEL_ROTATOR_busy_Out     (busy),
    .SC_GLOBAL_VEL_ROTATOR_sat_Out      (sat)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Start in cycle 0, scramble inputs afterwards, and check latency, busy and results.
  // With stray=1 a second start is also raised in cycle 10 and in the DONE cycle.
  task automatic run(input string tag, input int ax, input int ay, input int ac, input int as_,
                     input int egx, input int egy, input int esat, input int stray);
    int n;
    int busy_lo;
    int extra;
    @(posedge clk); #1;
    vx = 16'(ax); vy = 16'(ay); cs = 16'(ac); sn = 16'(as_); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 1; busy_lo = 0;
    vx = -16'sd1234; vy = 16'sd777; cs = -16'sd5; sn = 16'sd99;
    while (!complete && n < 200) begin
      if (!busy) busy_lo++;
      @(posedge clk); #1;
      n++;
      start = (stray != 0 && n == 10);
    end
    check({tag, "_latency"}, n, 74);
    check({tag, "_busy_low_cycles"}, busy_lo, 0);
    check({tag, "_gx"}, gx, egx);
    check({tag, "_gy"}, gy, egy);
    check({tag, "_sat"}, sat, esat);
    start = (stray != 0);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_complete_one_cycle"}, complete, 0);
    check({tag, "_idle_after_done"}, busy, 0);
    if (stray != 0) begin
      extra = 0;
      repeat (80) begin
        @(posedge clk); #1;
        if (complete) extra++;
      end
      check({tag, "_extra_completes"}, extra, 0);
    end
  endtask

  initial begin
    int extra;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gx", gx, 0);
    check("rst_gy", gy, 0);
    check("rst_busy", busy, 0);
    check("rst_complete", complete, 0);
    check("rst_sat", sat, 0);
    rst = 1'b0;

    run("t1_identity", 1000, 0, 16384, 0, 1000, 0, 0, 0);
    run("t2_quarter", 1000, 500, 0, 16384, -500, 1000, 0, 0);
    run("t3_round", 10000, 10000, 11585, 11585, 0, 14142, 0, 0);
    run("t4_sat_pos", 32767, 32767, 16384, 16384, 0, 32767, 1, 0);
    run("t4_sat_neg", -32768, 0, -16384, 0, 32767, 0, 1, 0);
    run("t5_stray", 1000, 500, 0, 16384, -500, 1000, 0, 1);

    // Abort at cycle 30 of a run; outputs must drop at once and no complete may follow.
    @(posedge clk); #1;
    vx = 16'sd1000; vy = 16'sd0; cs = 16'sd16384; sn = 16'sd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("t6_busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_gx", gx, 0);
    check("t6_rst_gy", gy, 0);
    check("t6_rst_complete", complete, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    extra = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (complete) extra++;
    end
    check("t6_no_complete", extra, 0);
    run("t6_after_rst", 10000, 10000, 11585, 11585, 0, 14142, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
